mem_port_arbiter3: RTL and testbench

- Controller that shares the single RV32I memory port among three requesters: 0 = instruction fetch, 1 = load/store unit, 2 = debug.
- Arbitrates round-robin and holds one grant for each whole transaction, request through response.
- Drives the 2-bit select of the word-wide 3-input address/wdata mux in front of the memory, plus the memory handshake and per-requester response routing.
- Allows at most one outstanding transaction, with a cycle-count timeout guard.

---
 rtl/mem_port_arbiter3.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter3.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter3.sv
// Round-robin owner of the single memory port shared by fetch (0), LSU (1) and debug (2).
// One transaction in flight at a time, guarded by a cycle-count timeout.
module mem_port_arbiter3 #(
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned CW        = $clog2(TO_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    input  logic       mem_ready,
    input  logic       mem_rvalid,
    output logic [2:0] rsp_valid,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    localparam logic [CW-1:0] CntLast = CW'(TO_CYCLES - 1);

    state_e        state_q;
    logic [1:0]    ptr_q;
    logic [1:0]    idx_q;
    logic [2:0]    gnt_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    logic [1:0] win_idx;
    logic [2:0] cand;
    logic       found;
    logic [1:0] ptr_nxt;
    logic       completion;
    logic       expire;

    // Scan ptr, ptr+1, ptr+2 (mod 3) and take the first requester found.
    always_comb begin
        win_idx = 2'd0;
        found   = 1'b0;
        cand    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && req[cand[1:0]]) begin
                found   = 1'b1;
                win_idx = cand[1:0];
            end
        end
    end

    assign ptr_nxt = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

    assign completion = ((state_q == StIssue) && mem_ready && mem_rvalid) ||
                        ((state_q == StWaitRsp) && mem_rvalid);

    // A completion on the last allowed cycle wins over the abort.
    assign expire = (state_q != StIdle) && !completion && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            gnt_q     <= 3'b000;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StIssue;
                        idx_q   <= win_idx;
                        gnt_q   <= 3'b001 << win_idx;
                        cnt_q   <= '0;
                    end
                end
                StIssue, StWaitRsp: begin
                    if (completion || expire) begin
                        state_q <= StIdle;
                        idx_q   <= 2'd0;
                        gnt_q   <= 3'b000;
                        ptr_q   <= ptr_nxt;
                        if (expire) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if ((state_q == StIssue) && mem_ready) begin
                            state_q <= StWaitRsp;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign sel       = idx_q;
    assign mem_valid = (state_q == StIssue);
    assign busy      = (state_q != StIdle);
    assign timeout   = timeout_q;
    assign rsp_valid = gnt_q & {3{completion}};

endmodule

// File: tb/tb_mem_port_arbiter3.sv
// Bench for mem_port_arbiter3: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter3;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic       mem_ready = 1'b0;
    logic       mem_rvalid = 1'b0;
    logic [2:0] rsp_valid;
    logic       busy;
    logic       timeout;

    always #5 clk = ~clk;

    mem_port_arbiter3 #(.TO_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .rsp_valid (rsp_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Model: who owns the port, whether memory has taken the request, how long it has lasted.
    bit m_known    = 0;
    bit m_owned    = 0;
    int m_owner    = 0;
    bit m_accepted = 0;
    int m_age      = 0;
    int m_ptr      = 0;
    bit m_timeout  = 0;
    int served     = 0;
    int aborts     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] r, input logic rdy, input logic rv, input logic rs);
        logic [2:0] e_gnt;
        bit done;
        @(negedge clk);
        req = r; mem_ready = rdy; mem_rvalid = rv; rst = rs;
        #1;
        e_gnt = m_owned ? 3'(1 << m_owner) : 3'b000;
        done  = m_owned && rv && (m_accepted || rdy);
        if (m_known) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("sel", 32'(sel), m_owned ? 32'(m_owner) : 32'd0);
            chk("mem_valid", 32'(mem_valid), 32'(m_owned && !m_accepted));
            chk("busy", 32'(busy), 32'(m_owned));
            chk("timeout", 32'(timeout), 32'(m_timeout));
            chk("rsp_valid", 32'(rsp_valid), done ? 32'(e_gnt) : 32'd0);
            chk("sel_not_3", 32'(sel == 2'b11), 32'd0);
        end
        // State as seen after the coming rising edge.
        if (rs) begin
            m_known = 1; m_owned = 0; m_accepted = 0; m_age = 0; m_ptr = 0; m_timeout = 0;
        end else if (!m_owned) begin
            for (int k = 0; k < 3; k++) begin
                if (!m_owned && r[(m_ptr + k) % 3]) begin
                    m_owned = 1; m_owner = (m_ptr + k) % 3; m_accepted = 0; m_age = 0;
                end
            end
        end else if (done) begin
            m_owned = 0; m_ptr = (m_owner + 1) % 3; served++;
        end else if (m_age == TO - 1) begin
            m_owned = 0; m_ptr = (m_owner + 1) % 3; m_timeout = 1; aborts++;
        end else begin
            m_age++;
            if (rdy) m_accepted = 1;
        end
    endtask

    initial begin
        bit stuck;
        int pct;
        step(3'b000, 0, 0, 1);
        step(3'b000, 0, 0, 1);
        step(3'b000, 0, 0, 0);

        // All requesting, memory answers instantly: 001,010,100,001 with idle gaps.
        for (int i = 0; i < 8; i++) step(3'b111, 1, 1, 0);
        step(3'b000, 0, 0, 1);
        step(3'b000, 0, 0, 0);

        // Requester 1: accepted in cycle 3, response in cycle 6.
        step(3'b010, 0, 0, 0);
        step(3'b010, 0, 0, 0);
        step(3'b010, 0, 0, 0);
        step(3'b010, 1, 0, 0);
        step(3'b010, 0, 0, 0);
        step(3'b010, 0, 0, 0);
        step(3'b000, 0, 1, 0);
        step(3'b000, 0, 0, 0);
        chk("busy_after_rsp", 32'(busy), 32'd0);

        // Memory never ready: abort after TO cycles, flag stays set.
        for (int i = 0; i < TO + 1; i++) step(3'b001, 0, 0, 0);
        step(3'b000, 0, 1, 0);
        chk("timeout_set", 32'(timeout), 32'd1);
        step(3'b100, 1, 0, 0);
        step(3'b100, 1, 0, 0);
        step(3'b000, 0, 1, 0);
        step(3'b000, 0, 0, 0);
        chk("timeout_sticky", 32'(timeout), 32'd1);
        step(3'b000, 0, 0, 1);
        step(3'b000, 0, 0, 0);
        chk("timeout_cleared", 32'(timeout), 32'd0);

        // Reset during WAIT_RSP, then 110 must go to requester 1.
        step(3'b001, 0, 0, 0);
        step(3'b001, 1, 0, 0);
        step(3'b000, 0, 0, 0);
        step(3'b000, 0, 1, 1);
        step(3'b110, 0, 0, 0);
        step(3'b110, 0, 0, 0);
        chk("gnt_after_rst", 32'(gnt), 32'h2);

        // Request dropped while waiting: transaction still completes.
        step(3'b000, 1, 0, 0);
        step(3'b000, 0, 0, 0);
        step(3'b000, 0, 0, 0);
        step(3'b000, 0, 1, 0);
        step(3'b000, 0, 0, 0);

        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) stuck = ~stuck;
            pct = stuck ? 3 : 60;
            step(3'($urandom), $urandom_range(0, 99) < pct, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 249) == 0);
        end
        step(3'b000, 0, 0, 0);
        chk("served_some", 32'(served > 20), 32'd1);
        chk("aborted_some", 32'(aborts > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
